// File: rtl/brent_accum.sv
// Operand-stream accumulator built around an N-bit Brent-Kung adder; returns the total over valid/ready.
// Optional build macro BRENT_ACCUM_SAT_EN: saturate the running total on carry-out instead of wrapping.

module Brent #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N:0]   Sum
);

    localparam int LVL = $clog2(N);

    // Brent-Kung prefix tree: up-sweep builds power-of-two spans, down-sweep fills the gaps.
    always_comb begin : prefix_blk
        logic [N-1:0] p;
        logic [N-1:0] gg;
        logic [N-1:0] pp;
        p     = A ^ B;
        gg    = A & B;
        pp    = p;
        gg[0] = gg[0] | (p[0] & Cin);
        for (int l = 0; (2 << l) <= int'(N); l++) begin
            for (int i = (2 << l) - 1; i < int'(N); i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
        for (int l = LVL - 2; l >= 0; l--) begin
            for (int i = 3 * (1 << l) - 1; i < int'(N); i += (2 << l)) begin
                gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                pp[i] = pp[i] & pp[i - (1 << l)];
            end
        end
        Sum[0] = p[0] ^ Cin;
        for (int i = 1; i < int'(N); i++) begin
            Sum[i] = p[i] ^ gg[i - 1];
        end
        Sum[N] = gg[N-1];
    end

endmodule

module brent_accum #(
    parameter int unsigned LEN_W = 4,
    parameter int unsigned N     = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N-1:0]     in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [N-1:0]     out_sum_o,
    output logic             out_ovf_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, out_valid_q, busy_q;
    logic [N:0]       sum_w;

    Brent #(.N(N)) u_brent (
        .A   (acc_q),
        .B   (in_data_i),
        .Cin (1'b0),
        .Sum (sum_w)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = len_i;
                    state_d = (len_i == '0) ? S_HOLD : S_ACC;
                end
            end
            S_ACC: begin
                if (in_valid_i) begin
                    acc_d = sum_w[N-1:0];
                    ovf_d = ovf_q | sum_w[N];
`ifdef BRENT_ACCUM_SAT_EN
                    if (sum_w[N] || ovf_q) begin
                        acc_d = '1;
                    end
`endif
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they align with state_q
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= (state_d == S_ACC);
            out_valid_q <= (state_d == S_HOLD);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign out_sum_o   = acc_q;
    assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_brent_accum.sv
// Directed bench for brent_accum: burst-level reference model compared every cycle, plus pinned literals.

module tb_brent_accum;

    localparam int unsigned LEN_W = 4;
    localparam int unsigned N     = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic             out_ovf;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    brent_accum #(.LEN_W(LEN_W), .N(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .len_i       (len),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sum_o   (out_sum),
        .out_ovf_o   (out_ovf),
        .busy_o      (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Burst-level reference: a running integer total, operands still owed, and whether the result is pending
    int m_acc;
    int m_left;
    bit m_busy;
    bit m_done;
    bit m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc = 0; m_left = 0; m_busy = 0; m_done = 0; m_ovf = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_acc  = 0;
                m_ovf  = 0;
                m_left = int'(len);
                m_busy = 1;
                m_done = (m_left == 0);
            end
        end else if (!m_done) begin
            if (in_valid) begin : add_blk
                int s;
                s = m_acc + int'(in_data);
                if (s > 255) begin
                    m_ovf = 1;
`ifdef BRENT_ACCUM_SAT_EN
                    s = 255;
`else
                    s = s - 256;
`endif
                end
                m_acc  = s;
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1;
            end
        end else if (out_ready) begin
            m_busy = 0;
            m_done = 0;
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", int'(busy), int'(m_busy));
        chk("cyc_in_ready", int'(in_ready), int'(m_busy && !m_done));
        chk("cyc_out_valid", int'(out_valid), int'(m_busy && m_done));
        chk("cyc_out_sum", int'(out_sum), m_acc);
        chk("cyc_out_ovf", int'(out_ovf), int'(m_ovf));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int l);
        start = 1'b1;
        len   = LEN_W'(l);
        step();
        start = 1'b0;
    endtask

    task automatic put(input int d);
        in_valid = 1'b1;
        in_data  = N'(d);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        chk(name, int'(out_valid), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step(); step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        rst = 1'b0;
        repeat (5) step();
        chk("idle_busy", int'(busy), 0);
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_in_ready", int'(in_ready), 0);
        chk("idle_out_sum", int'(out_sum), 0);

        // three back-to-back operands
        start_burst(3);
        chk("b3_busy_after_start", int'(busy), 1);
        put(10); put(20);
        chk("b3_not_valid_early", int'(out_valid), 0);
        put(30);
        chk("b3_valid_next_cycle", int'(out_valid), 1);
        chk("b3_sum", int'(out_sum), 60);
        chk("b3_ovf", int'(out_ovf), 0);
        step();
        chk("b3_done_idle", int'(busy), 0);

        // carry-out
        start_burst(2);
        put(200); put(100);
        wait_out("ovf_valid");
`ifdef BRENT_ACCUM_SAT_EN
        chk("ovf_sum_sat", int'(out_sum), 255);
`else
        chk("ovf_sum_wrap", int'(out_sum), 44);
`endif
        chk("ovf_flag", int'(out_ovf), 1);
        step();

        // gaps on input, backpressure on output, start and in_valid during HOLD ignored
        out_ready = 1'b0;
        start_burst(4);
        put(1); step(); put(2); step(); step(); put(3); put(4);
        chk("bp_sum", int'(out_sum), 10);
        in_valid = 1'b1; in_data = 8'd99;
        start = 1'b1; len = 4'd5;
        step();
        start = 1'b0;
        step(); step();
        chk("bp_valid_held", int'(out_valid), 1);
        chk("bp_sum_held", int'(out_sum), 10);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_start_ignored_busy", int'(busy), 0);
        chk("bp_start_ignored_ready", int'(in_ready), 0);

        // zero-length burst, operand offered but not consumed
        in_valid = 1'b1; in_data = 8'd55;
        start_burst(0);
        chk("len0_valid", int'(out_valid), 1);
        chk("len0_sum", int'(out_sum), 0);
        chk("len0_ovf", int'(out_ovf), 0);
        chk("len0_in_ready", int'(in_ready), 0);
        step();
        in_valid = 1'b0;
        chk("len0_idle", int'(busy), 0);

        // maximum length: 15 x 17 = 255 exactly, no carry
        start_burst(15);
        for (int i = 0; i < 15; i++) put(17);
        chk("max_valid", int'(out_valid), 1);
        chk("max_sum", int'(out_sum), 255);
        chk("max_ovf", int'(out_ovf), 0);
        step();

        // reset mid-burst discards the partial sum
        start_burst(5);
        put(3); put(4);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_sum", int'(out_sum), 0);
        chk("midrst_out_ovf", int'(out_ovf), 0);
        step();
        rst = 1'b0;
        step();
        start_burst(1);
        put(7);
        chk("after_rst_valid", int'(out_valid), 1);
        chk("after_rst_sum", int'(out_sum), 7);
        chk("after_rst_ovf", int'(out_ovf), 0);
        step();
        chk("after_rst_idle", int'(busy), 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
